// File: rtl/four_phase_fifo.sv
// four_phase_fifo
// Elastic buffer between two four-phase (return-to-zero) bundled-data
// handshakes. Upstream words are written into a DEPTH-entry circular buffer
// and re-issued downstream with a registered data bus. Handshake inputs pass
// through SYNC synchroniser flops unless SYNC is 0.
//
// Handshake rules:
//   Upstream: up_data is valid from the rise of up_req to the rise of up_ack.
//   The word is captured when up_ack rises. The producer then drops up_req,
//   and up_ack drops in reply.
//   Downstream: dn_data is valid and frozen while dn_req is high. The word is
//   popped when dn_req falls in reply to dn_ack. The consumer then drops
//   dn_ack before the next word can be offered.
module four_phase_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_req,
    output logic                     up_ack,
    input  logic [WIDTH-1:0]         up_data,
    output logic                     dn_req,
    input  logic                     dn_ack,
    output logic [WIDTH-1:0]         dn_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_RTZ  = 2'd2
    } out_state_t;

    logic             req_s;
    logic             ack_s;
    in_state_t        in_state;
    in_state_t        in_next;
    out_state_t       out_state;
    out_state_t       out_next;
    logic             wr_en;
    logic             ld_en;
    logic             pop_en;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronise the two incoming handshake lines (or pass them through).
    generate
        if (SYNC == 0) begin : g_nosync
            assign req_s = up_req;
            assign ack_s = dn_ack;
        end else begin : g_sync
            logic [SYNC-1:0] req_chain;
            logic [SYNC-1:0] ack_chain;

            // Shift chains; all flops clear on reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    req_chain <= '0;
                    ack_chain <= '0;
                end else begin
                    req_chain[0] <= up_req;
                    ack_chain[0] <= dn_ack;
                    for (int i = 1; i < SYNC; i++) begin
                        req_chain[i] <= req_chain[i-1];
                        ack_chain[i] <= ack_chain[i-1];
                    end
                end
            end

            assign req_s = req_chain[SYNC-1];
            assign ack_s = ack_chain[SYNC-1];
        end
    endgenerate

    // Input FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state <= IN_IDLE;
        end else begin
            in_state <= in_next;
        end
    end

    // Input FSM next state: accept a word only when not full (registered full,
    // so a pop on the same edge cannot open a slot until the following edge).
    always_comb begin
        in_next = in_state;
        wr_en   = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (req_s && !full) begin
                    wr_en   = 1'b1;
                    in_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!req_s) begin
                    in_next = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // The one-bit input state flop is the acknowledge itself: glitch-free.
    assign up_ack = (in_state == IN_ACK);

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state <= OUT_IDLE;
        end else begin
            out_state <= out_next;
        end
    end

    // Output FSM next state: load from registered empty (no bypass), pop on
    // ack, then wait for the consumer to return to zero.
    always_comb begin
        out_next = out_state;
        ld_en    = 1'b0;
        pop_en   = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (!empty) begin
                    ld_en    = 1'b1;
                    out_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_s) begin
                    pop_en   = 1'b1;
                    out_next = OUT_RTZ;
                end
            end
            OUT_RTZ: begin
                if (!ack_s) begin
                    out_next = OUT_IDLE;
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // Downstream request and data flops; dn_data only changes on a load,
    // which can only happen while dn_req is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_req  <= 1'b0;
            dn_data <= '0;
        end else begin
            if (ld_en) begin
                dn_req  <= 1'b1;
                dn_data <= mem[rptr];
            end else if (pop_en) begin
                dn_req  <= 1'b0;
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= up_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy: the offered word stays counted until it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_four_phase_fifo.sv
// Bench for four_phase_fifo: default instance (WIDTH=16, DEPTH=4, SYNC=2)
// plus a SYNC=0, WIDTH=32, DEPTH=2 instance.
module tb_four_phase_fifo;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        up_req;
    logic        up_ack;
    logic [15:0] up_data;
    logic        dn_req;
    logic        dn_ack;
    logic [15:0] dn_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    four_phase_fifo #(.WIDTH(16), .DEPTH(4), .SYNC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .up_req  (up_req),
        .up_ack  (up_ack),
        .up_data (up_data),
        .dn_req  (dn_req),
        .dn_ack  (dn_ack),
        .dn_data (dn_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // ---------------- SYNC=0 DUT ----------------
    logic        up_req0;
    logic        up_ack0;
    logic [31:0] up_data0;
    logic        dn_req0;
    logic        dn_ack0;
    logic [31:0] dn_data0;
    logic [1:0]  count0;
    logic        full0;
    logic        empty0;

    four_phase_fifo #(.WIDTH(32), .DEPTH(2), .SYNC(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .up_req  (up_req0),
        .up_ack  (up_ack0),
        .up_data (up_data0),
        .dn_req  (dn_req0),
        .dn_ack  (dn_ack0),
        .dn_data (dn_data0),
        .count   (count0),
        .full    (full0),
        .empty   (empty0)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int checks;
    int errors;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout_exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s actual=no_event required=event", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        up_req = 1'b0;
        dn_ack = 1'b0;
        up_req0 = 1'b0;
        dn_ack0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Full upstream four-phase cycle; expected word queued when driven.
    task automatic send(input logic [15:0] d);
        int n;
        @(negedge clk);
        up_data = d;
        up_req  = 1'b1;
        exp_q.push_back(d);
        n = 0;
        while (up_ack !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (up_ack !== 1'b1) timeout("up_ack_rise");
        @(negedge clk);
        up_req = 1'b0;
        n = 0;
        while (up_ack !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (up_ack !== 1'b0) timeout("up_ack_fall");
    endtask

    task automatic wait_dn_req(output bit ok);
        int n;
        n = 0;
        while (dn_req !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (dn_req === 1'b1);
        if (!ok) timeout("dn_req_rise");
    endtask

    // Compare the offered word against the scoreboard head.
    task automatic sb_compare(output logic [15:0] got);
        logic [15:0] e;
        got = dn_data;
        if (exp_q.size() == 0) begin
            timeout("sb_empty");
        end else begin
            e = exp_q.pop_front();
            chk("sb_data", dn_data, e);
        end
    endtask

    // Full downstream four-phase cycle with a consumer delay before ack.
    task automatic recv(input int delay, output logic [15:0] got);
        bit ok;
        int n;
        got = '0;
        wait_dn_req(ok);
        if (ok) begin
            sb_compare(got);
            repeat (delay) @(negedge clk);
            chk("dn_data_hold", dn_data, got);
            @(negedge clk);
            dn_ack = 1'b1;
            n = 0;
            while (dn_req !== 1'b0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (dn_req !== 1'b0) timeout("dn_req_fall");
            @(negedge clk);
            dn_ack = 1'b0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] got;
        bit ok;
        bit stalled;
        bit quiet;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        up_req = 1'b0;
        up_data = '0;
        dn_ack = 1'b0;
        up_req0 = 1'b0;
        up_data0 = '0;
        dn_ack0 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tbl[i].din      = 16'h0100 + 16'(i);
            tbl[i].dout_exp = 16'h0100 + 16'(i);
        end

        do_reset();

        // ---- reset state ----
        chk("rst_up_ack", up_ack, 0);
        chk("rst_dn_req", dn_req, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);

        // ---- single transfer, edge-exact ----
        up_data = 16'hA5A5;
        up_req  = 1'b1;
        exp_q.push_back(16'hA5A5);
        @(posedge clk); #1;
        chk("t1_e0_up_ack", up_ack, 0);
        @(posedge clk); #1;
        chk("t1_e1_up_ack", up_ack, 0);
        @(posedge clk); #1;
        chk("t1_e2_up_ack", up_ack, 1);
        chk("t1_e2_count", count, 1);
        chk("t1_e2_dn_req", dn_req, 0);
        @(posedge clk); #1;
        chk("t1_e3_dn_req", dn_req, 1);
        sb_compare(got);
        @(negedge clk);
        up_req = 1'b0;
        dn_ack = 1'b1;
        @(posedge clk); #1;
        chk("t1_f0_dn_req", dn_req, 1);
        @(posedge clk); #1;
        chk("t1_f1_up_ack", up_ack, 1);
        @(posedge clk); #1;
        chk("t1_f2_dn_req", dn_req, 0);
        chk("t1_f2_up_ack", up_ack, 0);
        chk("t1_f2_count", count, 0);
        chk("t1_f2_empty", empty, 1);
        @(negedge clk);
        dn_ack = 1'b0;
        repeat (4) @(negedge clk);

        // ---- fill with stalled consumer ----
        for (int i = 1; i <= 4; i++) send(16'(i));
        chk("t2_count4", count, 4);
        chk("t2_full", full, 1);
        chk("t2_empty", empty, 0);
        @(negedge clk);
        up_data = 16'h0005;
        up_req  = 1'b1;
        exp_q.push_back(16'h0005);
        stalled = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (up_ack !== 1'b0) stalled = 1'b0;
        end
        chk("t2_fifth_stalled", stalled, 1);
        chk("t2_dn_req", dn_req, 1);
        sb_compare(got);
        @(negedge clk);
        dn_ack = 1'b1;
        @(posedge clk); #1;
        chk("t2_f0_up_ack", up_ack, 0);
        @(posedge clk); #1;
        chk("t2_f1_count", count, 4);
        @(posedge clk); #1;
        chk("t2_f2_dn_req", dn_req, 0);
        chk("t2_f2_count", count, 3);
        chk("t2_f2_full", full, 0);
        chk("t2_f2_up_ack", up_ack, 0);
        @(posedge clk); #1;
        chk("t2_f3_up_ack", up_ack, 1);
        chk("t2_f3_count", count, 4);
        chk("t2_f3_full", full, 1);
        @(negedge clk);
        up_req = 1'b0;
        dn_ack = 1'b0;
        for (int i = 0; i < 4; i++) recv(0, got);
        repeat (6) @(negedge clk);
        chk("t2_drained_empty", empty, 1);

        // ---- wrap-around, table driven, slow consumer ----
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(tbl[i].din);
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [15:0] g;
                    recv(int'($urandom_range(0, 6)), g);
                    chk("t3_wrap_order", g, tbl[i].dout_exp);
                end
            end
        join
        repeat (6) @(negedge clk);
        chk("t3_empty", empty, 1);
        chk("t3_sb_left", exp_q.size(), 0);

        // ---- simultaneous write and pop at count=2, write at wrapped ptr ----
        do_reset();
        for (int i = 0; i < 4; i++) send(16'h0200 + 16'(i));
        recv(0, got);
        recv(0, got);
        wait_dn_req(ok);
        chk("t4_count2", count, 2);
        sb_compare(got);
        @(negedge clk);
        up_data = 16'h0204;
        up_req  = 1'b1;
        exp_q.push_back(16'h0204);
        dn_ack  = 1'b1;
        @(posedge clk); #1;
        chk("t4_e0_count", count, 2);
        @(posedge clk); #1;
        chk("t4_e1_count", count, 2);
        @(posedge clk); #1;
        chk("t4_e2_count", count, 2);
        chk("t4_e2_up_ack", up_ack, 1);
        chk("t4_e2_dn_req", dn_req, 0);
        @(negedge clk);
        up_req = 1'b0;
        dn_ack = 1'b0;
        recv(1, got);
        recv(0, got);
        chk("t4_last_word", got, 16'h0204);
        repeat (6) @(negedge clk);
        chk("t4_empty", empty, 1);

        // ---- reset during OUT_REQ with count=3 ----
        do_reset();
        for (int i = 0; i < 3; i++) send(16'h0A00 + 16'(i));
        wait_dn_req(ok);
        chk("t5_count3", count, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_up_ack", up_ack, 0);
        chk("t5_dn_req", dn_req, 0);
        chk("t5_dn_data", dn_data, 0);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        send(16'h7777);
        recv(0, got);
        chk("t5_fresh_word", got, 16'h7777);
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (dn_req !== 1'b0) quiet = 1'b0;
        end
        chk("t5_no_stale", quiet, 1);
        chk("t5_empty_after", empty, 1);

        // ---- SYNC=0, WIDTH=32, DEPTH=2 ----
        @(negedge clk);
        up_data0 = 32'hDEADBEEF;
        up_req0  = 1'b1;
        @(posedge clk); #1;
        chk("t6_e0_up_ack", up_ack0, 1);
        chk("t6_e0_count", count0, 1);
        chk("t6_e0_dn_req", dn_req0, 0);
        @(posedge clk); #1;
        chk("t6_e1_dn_req", dn_req0, 1);
        chk("t6_e1_dn_data", dn_data0, 32'hDEADBEEF);
        @(negedge clk);
        up_req0 = 1'b0;
        @(posedge clk); #1;
        chk("t6_up_ack_fall", up_ack0, 0);
        @(negedge clk);
        up_data0 = 32'h12345678;
        up_req0  = 1'b1;
        @(posedge clk); #1;
        chk("t6_second_ack", up_ack0, 1);
        chk("t6_count2", count0, 2);
        chk("t6_full", full0, 1);
        chk("t6_dn_data_hold", dn_data0, 32'hDEADBEEF);
        @(negedge clk);
        up_req0 = 1'b0;
        dn_ack0 = 1'b1;
        @(posedge clk); #1;
        chk("t6_pop_dn_req", dn_req0, 0);
        chk("t6_pop_count", count0, 1);
        chk("t6_pop_full", full0, 0);
        @(negedge clk);
        dn_ack0 = 1'b0;
        @(posedge clk); #1;
        chk("t6_rtz_dn_req", dn_req0, 0);
        @(posedge clk); #1;
        chk("t6_next_dn_req", dn_req0, 1);
        chk("t6_next_dn_data", dn_data0, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
